// File: rtl/seq_alu.sv
// Multi-cycle PASS_B/ADD/SUB/MUL ALU feeding the accumulator; 1-cycle ops finish 1 cycle after accept, MUL after data_width+1.
// No backpressure: start is only accepted in IDLE and dropped otherwise. SEQ_ALU_MUL_SAT_EN saturates an overflowing MUL.
module seq_alu #(
    parameter int data_width = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [1:0]            op,
    input  logic [data_width-1:0] a,
    input  logic [data_width-1:0] b,
    output logic [data_width-1:0] result,
    output logic                  acc_we,
    output logic                  done,
    output logic                  busy,
    output logic                  carry,
    output logic                  ovf
);
    localparam int CW = $clog2(data_width + 1);
    localparam int PW = 2 * data_width;

    typedef enum logic [1:0] {S_IDLE, S_MUL_RUN, S_DONE} state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [PW-1:0]         r_mcand;
    logic [PW-1:0]         r_prod;
    logic [data_width-1:0] r_mplier;
    logic [CW-1:0]         r_cnt;
    logic [data_width-1:0] r_result;
    logic                  r_carry;
    logic                  r_ovf;

    logic [data_width:0]   w_sum;
    logic [data_width-1:0] w_diff;
    logic [PW-1:0]         w_prod_nxt;
    logic                  w_prod_hi;
    logic [data_width-1:0] w_mul_res;
    logic                  w_mul_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = (op == 2'b11) ? S_MUL_RUN : S_DONE;
                end
            end
            S_MUL_RUN: begin
                if (w_mul_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // The last multiply step is folded into the finishing edge so MUL_RUN lasts exactly data_width cycles.
    always_comb begin
        w_sum      = {1'b0, a} + {1'b0, b};
        w_diff     = a - b;
        w_prod_nxt = r_prod + (r_mplier[0] ? r_mcand : '0);
        w_prod_hi  = |w_prod_nxt[PW-1:data_width];
        w_mul_last = (r_cnt == CW'(1));
`ifdef SEQ_ALU_MUL_SAT_EN
        w_mul_res  = w_prod_hi ? '1 : w_prod_nxt[data_width-1:0];
`else
        w_mul_res  = w_prod_nxt[data_width-1:0];
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mcand  <= '0;
            r_prod   <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
            r_result <= '0;
            r_carry  <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        case (op)
                            2'b00: begin
                                r_result <= b;
                                r_carry  <= 1'b0;
                                r_ovf    <= 1'b0;
                            end
                            2'b01: begin
                                r_result <= w_sum[data_width-1:0];
                                r_carry  <= w_sum[data_width];
                                r_ovf    <= 1'b0;
                            end
                            2'b10: begin
                                r_result <= w_diff;
                                r_carry  <= (a < b);
                                r_ovf    <= 1'b0;
                            end
                            default: begin
                                r_mcand  <= {{data_width{1'b0}}, a};
                                r_mplier <= b;
                                r_prod   <= '0;
                                r_cnt    <= CW'(data_width);
                            end
                        endcase
                    end
                end
                S_MUL_RUN: begin
                    r_prod   <= w_prod_nxt;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt - CW'(1);
                    if (w_mul_last) begin
                        r_result <= w_mul_res;
                        r_carry  <= 1'b0;
                        r_ovf    <= w_prod_hi;
                    end
                end
                default: ;
            endcase
        end
    end

    assign result = r_result;
    assign carry  = r_carry;
    assign ovf    = r_ovf;
    assign done   = (r_state == S_DONE);
    assign acc_we = (r_state == S_DONE);
    assign busy   = (r_state != S_IDLE);
endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu: vector table of single operations plus hand sequences for MUL corner cases.
module tb_seq_alu;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] result;
    logic        acc_we;
    logic        done;
    logic        busy;
    logic        carry;
    logic        ovf;

    int n_tests = 0;
    int n_fail  = 0;

`ifdef SEQ_ALU_MUL_SAT_EN
    localparam logic SAT = 1'b1;
`else
    localparam logic SAT = 1'b0;
`endif

    seq_alu #(.data_width(16)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .result (result),
        .acc_we (acc_we),
        .done   (done),
        .busy   (busy),
        .carry  (carry),
        .ovf    (ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       nm;
        logic [1:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] res;
        logic        c;
        logic        v;
        int          lat;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Issues one operation and checks latency, outputs and the single-cycle strobe.
    task automatic run_op(input string nm, input logic [1:0] t_op, input logic [15:0] t_a,
                          input logic [15:0] t_b, input logic [15:0] t_res, input logic t_c,
                          input logic t_v, input int t_lat);
        int cyc;
        @(negedge clk);
        op = t_op; a = t_a; b = t_b; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        cyc = 1;
        while (!done && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk({nm, ".latency"}, 32'(cyc), 32'(t_lat));
        chk({nm, ".result"}, 32'(result), 32'(t_res));
        chk({nm, ".carry"}, 32'(carry), 32'(t_c));
        chk({nm, ".ovf"}, 32'(ovf), 32'(t_v));
        chk({nm, ".acc_we"}, 32'(acc_we), 32'(1));
        @(posedge clk);
        #1;
        chk({nm, ".done_low"}, 32'({done, acc_we}), 32'(0));
    endtask

    initial begin
        int npulse;
        int dcyc;
        int nbusy;
        logic [15:0] dres;

        vecs[0]  = '{"add_carry",  2'b01, 16'hFFFF, 16'h0002, 16'h0001, 1'b1, 1'b0, 1};
        vecs[1]  = '{"add_small",  2'b01, 16'h0003, 16'h0004, 16'h0007, 1'b0, 1'b0, 1};
        vecs[2]  = '{"add_wrap",   2'b01, 16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b0, 1};
        vecs[3]  = '{"sub_borrow", 2'b10, 16'h0000, 16'h0001, 16'hFFFF, 1'b1, 1'b0, 1};
        vecs[4]  = '{"sub_plain",  2'b10, 16'h0005, 16'h0003, 16'h0002, 1'b0, 1'b0, 1};
        vecs[5]  = '{"sub_equal",  2'b10, 16'h0007, 16'h0007, 16'h0000, 1'b0, 1'b0, 1};
        vecs[6]  = '{"pass_b",     2'b00, 16'h1234, 16'hABCD, 16'hABCD, 1'b0, 1'b0, 1};
        vecs[7]  = '{"mul_basic",  2'b11, 16'h0012, 16'h0034, 16'h03A8, 1'b0, 1'b0, 17};
        vecs[8]  = '{"mul_ovf",    2'b11, 16'h0100, 16'h0100, SAT ? 16'hFFFF : 16'h0000, 1'b0, 1'b1, 17};
        vecs[9]  = '{"mul_max",    2'b11, 16'hFFFF, 16'hFFFF, SAT ? 16'hFFFF : 16'h0001, 1'b0, 1'b1, 17};
        vecs[10] = '{"mul_fit",    2'b11, 16'h00FF, 16'h0101, 16'hFFFF, 1'b0, 1'b0, 17};
        vecs[11] = '{"mul_zero",   2'b11, 16'h0000, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 17};

        rst_n = 1'b0; start = 1'b0; op = 2'b00; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset.result", 32'(result), 32'(0));
        chk("reset.flags", 32'({acc_we, done, busy, carry, ovf}), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i].nm, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res,
                   vecs[i].c, vecs[i].v, vecs[i].lat);
        end

        // Operand changes and start requests while busy must be ignored.
        @(negedge clk);
        op = 2'b11; a = 16'h0012; b = 16'h0034; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        npulse = 0; dcyc = 0; nbusy = 0; dres = '0;
        for (int i = 1; i <= 20; i++) begin
            if (done) begin
                npulse++;
                dcyc = i;
                dres = result;
            end
            if (busy) nbusy++;
            if (i == 3) begin
                a = 16'hFFFF; b = 16'hFFFF; op = 2'b01; start = 1'b1;
            end
            if (i == 5) start = 1'b0;
            if (i == 16) start = 1'b1;
            if (i == 17) start = 1'b0;
            @(posedge clk);
            #1;
        end
        chk("busy_seq.pulses", 32'(npulse), 32'(1));
        chk("busy_seq.done_cycle", 32'(dcyc), 32'(17));
        chk("busy_seq.result", 32'(dres), 32'h03A8);
        chk("busy_seq.busy_cycles", 32'(nbusy), 32'(17));
        chk("busy_seq.idle_after", 32'(busy), 32'(0));
        run_op("after_busy_add", 2'b01, 16'h0010, 16'h0020, 16'h0030, 1'b0, 1'b0, 1);

        repeat (3) @(posedge clk);
        #1;
        chk("hold.result", 32'(result), 32'h0030);
        chk("hold.done", 32'({done, acc_we}), 32'(0));

        // Reset in the middle of a multiply aborts it without a strobe.
        @(negedge clk);
        op = 2'b11; a = 16'h0FFF; b = 16'h0FFF; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort.result", 32'(result), 32'(0));
        chk("abort.flags", 32'({acc_we, done, busy, carry, ovf}), 32'(0));
        npulse = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (done || acc_we) npulse++;
            if (i == 3) rst_n = 1'b1;
        end
        chk("abort.no_pulse", 32'(npulse), 32'(0));
        run_op("post_reset_add", 2'b01, 16'h0003, 16'h0004, 16'h0007, 1'b0, 1'b0, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
